vga_sdram_line_cache: RTL and testbench

Parametrised multi-line read cache between the VGA pixel pipeline and the SDRAM controller. It supersedes the single-line VGA SDRAM interface: N cache lines, configurable line length, and per-request pixel depth of 8, 16 or 32 bpp. It can optionally prefetch the next sequential line so scanout does not stall at line boundaries. It has one SDRAM read port, with at most one burst outstanding.

---
 rtl/vga_sdram_line_cache_pkg.sv | 35 +++
 rtl/vga_sdram_line_cache_if.sv | 23 ++
 rtl/vga_sdram_line_cache_data_ram.sv | 33 +++
 rtl/vga_sdram_line_cache.sv | 186 ++++++++++++++++++
 tb/tb_vga_sdram_line_cache.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sdram_line_cache_pkg.sv
// Shared types and the pixel extraction helper for the VGA SDRAM line cache.
package vga_cache_pkg;

    typedef enum logic [1:0] {
        MODE_8BPP  = 2'd0,
        MODE_16BPP = 2'd1,
        MODE_32BPP = 2'd2
    } pixel_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } fsm_t;

    // Mode 3 is reserved and falls through to the full-word case.
    function automatic logic [31:0] extract_pixel(input logic [31:0] word,
                                                  input logic [1:0]  lsb,
                                                  input logic [1:0]  mode);
        logic [31:0] res;
        res = word;
        if (mode == MODE_8BPP) begin
            case (lsb)
                2'd0:    res = {24'h0, word[7:0]};
                2'd1:    res = {24'h0, word[15:8]};
                2'd2:    res = {24'h0, word[23:16]};
                default: res = {24'h0, word[31:24]};
            endcase
        end else if (mode == MODE_16BPP) begin
            res = lsb[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_sdram_line_cache_if.sv
// SDRAM burst read port between the line cache (master) and the SDRAM controller (slave).
interface vga_sdram_line_cache_if #(
    parameter int ADDR_W = 26
);
    // req/addr are held stable from assertion until the cycle ack is seen;
    // rdvalid qualifies rdata, complete marks the end of the single burst in flight.
    logic              vga_sdram_req;
    logic [ADDR_W-1:0] vga_sdram_addr;
    logic              vga_sdram_ack;
    logic [31:0]       vga_sdram_rdata;
    logic              vga_sdram_rdvalid;
    logic              vga_sdram_complete;

    modport master (
        output vga_sdram_req, vga_sdram_addr,
        input  vga_sdram_ack, vga_sdram_rdata, vga_sdram_rdvalid, vga_sdram_complete
    );

    modport slave (
        input  vga_sdram_req, vga_sdram_addr,
        output vga_sdram_ack, vga_sdram_rdata, vga_sdram_rdvalid, vga_sdram_complete
    );
endinterface

// File: rtl/vga_sdram_line_cache_data_ram.sv
// Line data storage: one write port, one registered read port (read data resets to 0).
module vga_cache_data_ram #(
    parameter int NUM_LINES  = 2,
    parameter int LINE_WORDS = 16,
    localparam int LINE_W    = $clog2(NUM_LINES),
    localparam int WORD_W    = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [LINE_W-1:0] wline_i,
    input  logic [WORD_W-1:0] wword_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    input  logic [LINE_W-1:0] rline_i,
    input  logic [WORD_W-1:0] rword_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] mem_q [NUM_LINES][LINE_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wline_i][wword_i] <= wdata_i;
    end

    // Read data only moves on a read, so the pixel output holds between hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[rline_i][rword_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_sdram_line_cache.sv
// Multi-line VGA read cache in front of an SDRAM burst port.
// Optional next-line prefetch is enabled with `define VGA_CACHE_PREFETCH_EN.
module vga_sdram_line_cache
    import vga_cache_pkg::*;
#(
    parameter int ADDR_W     = 26,
    parameter int NUM_LINES  = 2,
    parameter int LINE_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pixel_addr,
    input  logic              pixel_addr_valid,
    input  logic [1:0]        pixel_mode,
    output logic [31:0]       pixel_data,
    output logic              pixel_data_valid,
    output logic              stall,
    vga_sdram_line_cache_if.master sdram
);
    localparam int OFS_W  = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W  = ADDR_W - OFS_W;
    localparam int LINE_W = $clog2(NUM_LINES);
    localparam int WORD_W = $clog2(LINE_WORDS);

    fsm_t              state_q, state_d;
    logic [TAG_W-1:0]  tag_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [LINE_W-1:0] vptr_q, fill_line_q;
    logic [TAG_W-1:0]  fill_tag_q;
    logic [WORD_W-1:0] wptr_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pdv_q;
    logic [1:0]        lsb_q, mode_q;

    logic [TAG_W-1:0]  req_tag, alloc_tag;
    logic              hit, alloc, pf_issue;
    logic [LINE_W-1:0] hit_line, victim;
    logic [31:0]       ram_rdata;

    assign req_tag = pixel_addr[ADDR_W-1:OFS_W];

    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] l);
        return (l == LINE_W'(NUM_LINES - 1)) ? '0 : l + 1'b1;
    endfunction

    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit      = 1'b1;
                hit_line = LINE_W'(i);
            end
        end
    end

    assign stall = pixel_addr_valid && !hit;

`ifdef VGA_CACHE_PREFETCH_EN
    logic [TAG_W-1:0] next_tag, last_pf_tag_q;
    logic             last_pf_vld_q, next_cached, pf_ok;

    assign next_tag = req_tag + 1'b1;

    always_comb begin
        next_cached = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && tag_q[i] == next_tag) next_cached = 1'b1;
        end
    end

    // Only evaluated in IDLE, so nothing can be in flight at that point.
    assign pf_ok = pixel_addr_valid && hit && !next_cached &&
                   !(last_pf_vld_q && last_pf_tag_q == req_tag);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pf_tag_q <= '0;
            last_pf_vld_q <= 1'b0;
        end else if (pf_issue) begin
            last_pf_tag_q <= req_tag;
            last_pf_vld_q <= 1'b1;
        end
    end
`endif

    // A line that hits this cycle is never picked as the victim.
    always_comb begin
        victim = vptr_q;
        if (hit && vptr_q == hit_line) victim = next_line(vptr_q);
    end

    always_comb begin
        state_d   = state_q;
        alloc     = 1'b0;
        alloc_tag = req_tag;
        pf_issue  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pixel_addr_valid && !hit) begin
                    alloc   = 1'b1;
                    state_d = REQ;
                end
`ifdef VGA_CACHE_PREFETCH_EN
                else if (pf_ok) begin
                    alloc     = 1'b1;
                    alloc_tag = next_tag;
                    pf_issue  = 1'b1;
                    state_d   = REQ;
                end
`endif
            end
            REQ:     if (sdram.vga_sdram_ack) state_d = FILL;
            FILL:    if (sdram.vga_sdram_complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
            valid_q     <= '0;
            vptr_q      <= '0;
            fill_line_q <= '0;
            fill_tag_q  <= '0;
            wptr_q      <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            pdv_q       <= 1'b0;
            lsb_q       <= '0;
            mode_q      <= '0;
        end else begin
            if (alloc) begin
                valid_q[victim] <= 1'b0;
                fill_tag_q      <= alloc_tag;
                fill_line_q     <= victim;
                addr_q          <= {alloc_tag, {OFS_W{1'b0}}};
                req_q           <= 1'b1;
                vptr_q          <= next_line(victim);
            end
            if (state_q == REQ && sdram.vga_sdram_ack) begin
                req_q  <= 1'b0;
                wptr_q <= '0;
            end
            if (state_q == FILL) begin
                if (sdram.vga_sdram_rdvalid) wptr_q <= wptr_q + 1'b1;
                if (sdram.vga_sdram_complete) begin
                    valid_q[fill_line_q] <= 1'b1;
                    tag_q[fill_line_q]   <= fill_tag_q;
                end
            end
            pdv_q <= pixel_addr_valid && hit;
            if (pixel_addr_valid && hit) begin
                lsb_q  <= pixel_addr[1:0];
                mode_q <= pixel_mode;
            end
        end
    end

    vga_cache_data_ram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .we_i    (state_q == FILL && sdram.vga_sdram_rdvalid),
        .wline_i (fill_line_q),
        .wword_i (wptr_q),
        .wdata_i (sdram.vga_sdram_rdata),
        .re_i    (pixel_addr_valid && hit),
        .rline_i (hit_line),
        .rword_i (pixel_addr[OFS_W-1:2]),
        .rdata_o (ram_rdata)
    );

    assign pixel_data           = extract_pixel(ram_rdata, lsb_q, mode_q);
    assign pixel_data_valid     = pdv_q;
    assign sdram.vga_sdram_req  = req_q;
    assign sdram.vga_sdram_addr = addr_q;
endmodule

// File: tb/tb_vga_sdram_line_cache.sv
// Directed bench for vga_sdram_line_cache: table-driven hit vectors plus miss/fill sequences.
module tb_vga_sdram_line_cache;
  localparam int ADDR_W = 26;
  localparam int LW     = 16;
  localparam int OFS_W  = 6;
  localparam int TAG_W  = ADDR_W - OFS_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] pixel_addr;
  logic              pixel_addr_valid;
  logic [1:0]        pixel_mode;
  logic [31:0]       pixel_data;
  logic              pixel_data_valid;
  logic              stall;

  vga_sdram_line_cache_if #(.ADDR_W(ADDR_W)) sd_if ();

  vga_sdram_line_cache #(.ADDR_W(ADDR_W), .NUM_LINES(2), .LINE_WORDS(LW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pixel_addr       (pixel_addr),
    .pixel_addr_valid (pixel_addr_valid),
    .pixel_mode       (pixel_mode),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .stall            (stall),
    .sdram            (sd_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int req_pulses = 0;
  logic req_prev = 1'b0;

  always @(posedge clk) begin
    if (sd_if.vga_sdram_req && !req_prev) req_pulses++;
    req_prev <= sd_if.vga_sdram_req;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        mode;
    logic [31:0]       exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [ADDR_W-1:0] a, input logic [1:0] m);
    pixel_addr       = a;
    pixel_mode       = m;
    pixel_addr_valid = 1'b1;
    #1;
  endtask

  // Line contents supplied by the bench's SDRAM responder.
  function automatic logic [31:0] gen_word(input logic [TAG_W-1:0] tag, input int k);
    if (tag == TAG_W'(32'h41))
      return (k == 0) ? 32'hAABBCCDD : 32'h41000000 + 32'(k) * 32'h11;
    return {tag[7:0], 24'h0} + 32'(k);
  endfunction

  // Answers one burst: waits for req, acks after ack_dly cycles, streams a line.
  task automatic serve(input logic [ADDR_W-1:0] exp_addr, input int ack_dly,
                       input bit coincide, input bit exp_stall, input string name);
    int n = 0;
    int stall_bad = 0;
    logic [TAG_W-1:0] tag;
    tag = exp_addr[ADDR_W-1:OFS_W];
    while (!sd_if.vga_sdram_req && n < 50) begin
      step();
      n++;
    end
    check({name, "_req"}, 32'(sd_if.vga_sdram_req), 32'd1);
    check({name, "_addr"}, 32'(sd_if.vga_sdram_addr), 32'(exp_addr));
    for (int i = 0; i < ack_dly; i++) begin
      if (stall !== exp_stall || !sd_if.vga_sdram_req) stall_bad++;
      step();
    end
    sd_if.vga_sdram_ack = 1'b1;
    step();
    sd_if.vga_sdram_ack = 1'b0;
    check({name, "_req_drop"}, 32'(sd_if.vga_sdram_req), 32'd0);
    for (int k = 0; k < LW; k++) begin
      sd_if.vga_sdram_rdvalid  = 1'b1;
      sd_if.vga_sdram_rdata    = gen_word(tag, k);
      sd_if.vga_sdram_complete = coincide && (k == LW - 1);
      #1;
      if (stall !== exp_stall) stall_bad++;
      step();
    end
    sd_if.vga_sdram_rdvalid  = 1'b0;
    sd_if.vga_sdram_complete = 1'b0;
    if (!coincide) begin
      sd_if.vga_sdram_complete = 1'b1;
      if (stall !== exp_stall) stall_bad++;
      step();
      sd_if.vga_sdram_complete = 1'b0;
    end
    check({name, "_stall_held"}, 32'(stall_bad), 32'd0);
  endtask

  initial begin
    int p0;
    vecs[0] = '{26'h001040, 2'd0, 32'h000000DD};
    vecs[1] = '{26'h001082, 2'd1, 32'h00004200};
    vecs[2] = '{26'h001043, 2'd0, 32'h000000AA};
    vecs[3] = '{26'h0010BC, 2'd3, 32'h4200000F};
    vecs[4] = '{26'h001042, 2'd1, 32'h0000AABB};
    vecs[5] = '{26'h001084, 2'd0, 32'h00000001};
    vecs[6] = '{26'h001040, 2'd2, 32'hAABBCCDD};
    vecs[7] = '{26'h001087, 2'd0, 32'h00000042};
    vecs[8] = '{26'h001041, 2'd1, 32'h0000CCDD};
    vecs[9] = '{26'h001047, 2'd0, 32'h00000041};

    reset_n                  = 1'b0;
    pixel_addr               = '0;
    pixel_mode               = 2'd0;
    pixel_addr_valid         = 1'b0;
    sd_if.vga_sdram_ack      = 1'b0;
    sd_if.vga_sdram_rdata    = '0;
    sd_if.vga_sdram_rdvalid  = 1'b0;
    sd_if.vga_sdram_complete = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    check("rst_req", 32'(sd_if.vga_sdram_req), 32'd0);
    check("rst_addr", 32'(sd_if.vga_sdram_addr), 32'd0);
    check("rst_pdv", 32'(pixel_data_valid), 32'd0);
    check("rst_pdata", pixel_data, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Cold read, 8bpp
    drive(26'h001040, 2'd0);
    check("cold_stall", 32'(stall), 32'd1);
    serve(26'h001040, 0, 1'b0, 1'b1, "cold");
    check("cold_nostall", 32'(stall), 32'd0);
    step();
    check("cold_pdv", 32'(pixel_data_valid), 32'd1);
    check("cold_data", pixel_data, 32'h000000DD);

    // Second line
    drive(26'h001082, 2'd1);
    check("fill42_stall", 32'(stall), 32'd1);
    serve(26'h001080, 0, 1'b0, 1'b1, "fill42");
    step();
    check("fill42_data", pixel_data, 32'h00004200);

    // Ping-pong hits, back to back
    p0 = req_pulses;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].addr, vecs[i].mode);
      check($sformatf("tbl%0d_stall", i), 32'(stall), 32'd0);
      step();
      check($sformatf("tbl%0d_pdv", i), 32'(pixel_data_valid), 32'd1);
      check($sformatf("tbl%0d_data", i), pixel_data, vecs[i].exp);
    end
    check("tbl_no_req", 32'(req_pulses), 32'(p0));
    pixel_addr_valid = 1'b0;
    step();
    check("idle_pdv", 32'(pixel_data_valid), 32'd0);
    check("idle_hold", pixel_data, 32'h00000041);

    // Miss held on the in-flight tag with a slow ack
    p0 = req_pulses;
    drive(26'h0010C0, 2'd2);
    serve(26'h0010C0, 5, 1'b0, 1'b1, "inflight");
    check("inflight_pulses", 32'(req_pulses), 32'(p0 + 1));
    check("inflight_nostall", 32'(stall), 32'd0);
    step();
    check("inflight_data", pixel_data, 32'h43000000);

    // rdvalid and complete on the same cycle; read the last word at once
    drive(26'h001100, 2'd2);
    serve(26'h001100, 0, 1'b1, 1'b1, "coinc");
    pixel_addr = 26'h00113C;
    #1;
    check("coinc_nostall", 32'(stall), 32'd0);
    step();
    check("coinc_pdv", 32'(pixel_data_valid), 32'd1);
    check("coinc_data", pixel_data, 32'h4400000F);

`ifdef VGA_CACHE_PREFETCH_EN
    // Hit on the top tag prefetches tag 0 without stalling
    drive({{TAG_W{1'b1}}, {OFS_W{1'b0}}}, 2'd2);
    serve({{TAG_W{1'b1}}, {OFS_W{1'b0}}}, 0, 1'b0, 1'b1, "pf_top");
    step();
    serve(26'h000000, 0, 1'b0, 1'b0, "pf_wrap");
    drive(26'h000000, 2'd2);
    check("pf_hit_stall", 32'(stall), 32'd0);
    step();
    check("pf_hit_pdv", 32'(pixel_data_valid), 32'd1);
    check("pf_hit_data", pixel_data, 32'h00000000);
`endif

    // Reset in the middle of a fill
    drive(26'h001140, 2'd2);
    step();
    check("rstfill_req", 32'(sd_if.vga_sdram_req), 32'd1);
    sd_if.vga_sdram_ack = 1'b1;
    step();
    sd_if.vga_sdram_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sd_if.vga_sdram_rdvalid = 1'b1;
      sd_if.vga_sdram_rdata   = 32'hDEAD0000 + 32'(k);
      step();
    end
    sd_if.vga_sdram_rdvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstfill_req_drop", 32'(sd_if.vga_sdram_req), 32'd0);
    check("rstfill_pdv", 32'(pixel_data_valid), 32'd0);
    check("rstfill_pdata", pixel_data, 32'd0);
    pixel_addr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    drive(26'h001100, 2'd2);
    check("rstfill_invalid", 32'(stall), 32'd1);
    pixel_addr_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
